dtree_classifier_mc: RTL and testbench
======================================

// Module: dtree_classifier_mc
// PURPOSE
//  Multi-channel decision-tree spike classifier: a controller and its own MAC datapath in one block.
//  Accepts one spike feature vector plus channel id and walks a heap-indexed binary tree of hyperplane nodes.
//  Each node computes bias + sum(coeff[k]*x[k]) serially and branches on the sign.
//  Emits leaf path/level over a valid/ready handshake.
//  Node tables live in an internal register array, loaded per channel through a config write port.
// PARAMETERS
//  FEATURES         3   features per spike / coefficients per node
//  FEATURE_WIDTH    8   signed feature width
//  COEFF_BIT_DEPTH  4   signed coefficient width
//  BIAS_BIT_DEPTH   10  signed bias width
//  TREE_DEPTH       3   max decisions per spike; NODES = 2**TREE_DEPTH-1 per channel
//  CHANNEL_COUNT    16  independent node tables
//  (localparam) NODE_W = 2+FEATURES*COEFF_BIT_DEPTH+BIAS_BIT_DEPTH
//  (localparam) ACC_W  = max(BIAS_BIT_DEPTH, FEATURE_WIDTH+COEFF_BIT_DEPTH)+$clog2(FEATURES+1)
// PORTS
//  clk          in   1                    clock, rising edge
//  reset        in   1                    asynchronous, active-high
//  in_valid     in   1                    spike vector present
//  in_ready     out  1                    block idle, will accept
//  in_channel   in   $clog2(CHANNEL_COUNT) channel id
//  in_features  in   FEATURES*FEATURE_WIDTH x[k] at bits [k*FW +: FW]
//  cfg_we       in   1                    node table write strobe
//  cfg_ready    out  1                    writes accepted (== in_ready)
//  cfg_addr     in   $clog2(CHANNEL_COUNT*NODES) ch*NODES+node
//  cfg_data     in   NODE_W               {flags[1:0], coeff[F-1]..coeff[0], bias}
//  out_valid    out  1                    result present
//  out_ready    in   1                    consumer accepts result
//  out_channel  out  $clog2(CHANNEL_COUNT) channel of result
//  out_level    out  $clog2(TREE_DEPTH+1) decisions taken, 1..TREE_DEPTH
//  out_path     out  TREE_DEPTH           path[d] = direction at depth d; bits >= level are 0
// BEHAVIOUR
//  States: IDLE, LOAD, MAC, DECIDE, DONE. Async reset -> IDLE.
//  Reset values: in_ready=cfg_ready=1, out_valid=0, out_* = 0.
//  Node array is not reset; its contents survive reset.
//  IDLE:
//   - in_ready=1.
//   - On in_valid: latch features and channel; node=0, depth=0, path=0; go to LOAD.
//  LOAD: acc <= sign-extended bias of node; k <= 0; go to MAC.
//  MAC: acc <= acc + sext(coeff[k])*sext(x[k]); k++.
//   - After k==FEATURES-1, go to DECIDE.
//   - Exactly FEATURES cycles; no zero skipping.
//  DECIDE:
//   - dir = ~acc[ACC_W-1] (acc>=0 -> right=1); path[depth] <= dir.
//   - flags[1] = right child valid, flags[0] = left child valid.
//   - If flags[dir] && depth<TREE_DEPTH-1: node <= 2*node+1+dir; depth++; go to LOAD.
//   - Else: out_level <= depth+1; go to DONE.
//  DONE: out_valid=1 and outputs held stable until out_ready; then go to IDLE.
//   - in_ready rises on the cycle after the out handshake.
//  Latency: L = decisions taken. out_valid rises FEATURES*L+2L+1 cycles after the accepting edge.
//  Out-of-range channel (in_channel >= CHANNEL_COUNT):
//   - Still accepted; goes straight to DONE.
//   - out_level=0, out_path=0, out_channel=in_channel.
//  cfg writes: node[cfg_addr] <= cfg_data at the edge when cfg_we && cfg_ready.
//   - Dropped silently when the block is busy or cfg_addr is out of range.
//  Simultaneous in_valid and cfg_we in IDLE:
//   - Both take effect on that edge.
//   - The walk reads the updated table from LOAD onward.
//  Arithmetic: full-precision signed in ACC_W bits; overflow is impossible by construction.
//  Reset mid-walk: the spike is discarded, no out_valid is produced, and the node table is kept.
// TESTING
//  - Reset: assert reset asynchronously mid-MAC -> same cycle out_valid=0, in_ready=1; table readback unchanged.
//  - Single node (F=3, ch2 root): flags=00, coeff=(1,-2,3), bias=-5, x=(4,1,1) -> acc=0, dir=1.
//    out_level=1, out_path=001, out_valid at T+6.
//  - Full depth 3: all flags=11, root acc<0 then nodes 1 and 4 acc>=0 -> path=110 (LSB first: 0,1,1), level=3.
//    Node sequence 0,1,4; out_valid at T+16.
//  - Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, cfg_we writes dropped.
//  - Edge cases:
//    - in_channel=CHANNEL_COUNT -> level 0 at T+1.
//    - Flags=10 with dir=0 -> terminates at depth 1.
//  - Extremes: all coeff=-8, x=127, bias=-512 -> no overflow, dir=0; per-channel isolation (ch0 vs ch15 tables differ).

Source files
------------

// File: rtl/dtree_classifier_mc.sv
// Multi-channel decision-tree spike classifier: walks a heap-indexed tree of
// hyperplane nodes per channel using a serial MAC, result via valid/ready.
`timescale 1ns/1ps
module dtree_classifier_mc #(
  parameter int FEATURES        = 3,
  parameter int FEATURE_WIDTH   = 8,
  parameter int COEFF_BIT_DEPTH = 4,
  parameter int BIAS_BIT_DEPTH  = 10,
  parameter int TREE_DEPTH      = 3,
  parameter int CHANNEL_COUNT   = 16,
  localparam int NODES  = 2**TREE_DEPTH - 1,
  localparam int NODE_W = 2 + FEATURES*COEFF_BIT_DEPTH + BIAS_BIT_DEPTH,
  localparam int ACC_W  = ((BIAS_BIT_DEPTH > FEATURE_WIDTH + COEFF_BIT_DEPTH) ?
                           BIAS_BIT_DEPTH : FEATURE_WIDTH + COEFF_BIT_DEPTH) + $clog2(FEATURES+1),
  localparam int CW     = $clog2(CHANNEL_COUNT),
  localparam int AW     = $clog2(CHANNEL_COUNT*NODES),
  localparam int LW     = $clog2(TREE_DEPTH+1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CW-1:0]                     in_channel,
  input  logic [FEATURES*FEATURE_WIDTH-1:0] in_features,
  input  logic                              cfg_we,
  output logic                              cfg_ready,
  input  logic [AW-1:0]                     cfg_addr,
  input  logic [NODE_W-1:0]                 cfg_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CW-1:0]                     out_channel,
  output logic [LW-1:0]                     out_level,
  output logic [TREE_DEPTH-1:0]             out_path
);
  localparam int NIW = $clog2(NODES);
  localparam int KW  = $clog2(FEATURES+1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DECIDE, S_DONE} state_t;
  state_t r_state, w_next;

  logic [NODE_W-1:0]        r_mem [CHANNEL_COUNT*NODES];
  logic [FEATURE_WIDTH-1:0] r_x [FEATURES];
  logic [CW-1:0]            r_ch;
  logic [NIW-1:0]           r_node;
  logic [LW-1:0]            r_depth;
  logic [LW-1:0]            r_level;
  logic [KW-1:0]            r_k;
  logic signed [ACC_W-1:0]  r_acc;
  logic [TREE_DEPTH-1:0]    r_path;

  logic                              w_in_range;
  logic [AW-1:0]                     w_rd_addr;
  logic [NODE_W-1:0]                 w_node;
  logic [1:0]                        w_flags;
  logic                              w_dir;
  logic                              w_descend;
  logic signed [BIAS_BIT_DEPTH-1:0]  w_bias;
  logic signed [COEFF_BIT_DEPTH-1:0] w_coeff;
  logic signed [FEATURE_WIDTH-1:0]   w_xk;
  logic signed [ACC_W-1:0]           w_bias_ext;
  logic signed [ACC_W-1:0]           w_coeff_ext;
  logic signed [ACC_W-1:0]           w_x_ext;
  logic signed [ACC_W-1:0]           w_prod;

  assign in_ready    = (r_state == S_IDLE);
  assign cfg_ready   = in_ready;
  assign out_valid   = (r_state == S_DONE);
  assign out_channel = r_ch;
  assign out_level   = r_level;
  assign out_path    = r_path;

  assign w_in_range = (int'(in_channel) < CHANNEL_COUNT);
  assign w_rd_addr  = AW'(r_ch) * AW'(NODES) + AW'(r_node);
  assign w_node     = r_mem[w_rd_addr];
  assign w_flags    = w_node[NODE_W-1 -: 2];
  assign w_dir      = ~r_acc[ACC_W-1];
  assign w_descend  = w_flags[w_dir] && (r_depth < LW'(TREE_DEPTH-1));

  always_comb begin
    w_bias      = w_node[BIAS_BIT_DEPTH-1:0];
    w_coeff     = w_node[BIAS_BIT_DEPTH + int'(r_k)*COEFF_BIT_DEPTH +: COEFF_BIT_DEPTH];
    w_xk        = r_x[r_k];
    w_bias_ext  = w_bias;
    w_coeff_ext = w_coeff;
    w_x_ext     = w_xk;
    w_prod      = w_coeff_ext * w_x_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = w_in_range ? S_LOAD : S_DONE;
      S_LOAD:   w_next = S_MAC;
      S_MAC:    if (r_k == KW'(FEATURES-1)) w_next = S_DECIDE;
      S_DECIDE: w_next = w_descend ? S_LOAD : S_DONE;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FEATURES; i++) r_x[i] <= '0;
      r_ch    <= '0;
      r_node  <= '0;
      r_depth <= '0;
      r_level <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_path  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          for (int unsigned i = 0; i < FEATURES; i++)
            r_x[i] <= in_features[i*FEATURE_WIDTH +: FEATURE_WIDTH];
          r_ch    <= in_channel;
          r_node  <= '0;
          r_depth <= '0;
          r_level <= '0;
          r_path  <= '0;
        end
        S_LOAD: begin
          r_acc <= w_bias_ext;
          r_k   <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod;
          r_k   <= r_k + KW'(1);
        end
        S_DECIDE: begin
          r_path[r_depth] <= w_dir;
          if (w_descend) begin
            r_node  <= NIW'(2*int'(r_node) + 1 + int'(w_dir));
            r_depth <= r_depth + LW'(1);
          end else begin
            r_level <= r_depth + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Node table has no reset so programmed trees survive a block reset.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_ready && (int'(cfg_addr) < CHANNEL_COUNT*NODES))
      r_mem[cfg_addr] <= cfg_data;
  end
endmodule

// File: tb/tb_dtree_classifier_mc.sv
// Scoreboard bench for dtree_classifier_mc: a behavioural tree-walk model
// predicts path/level/latency for each spike.
`timescale 1ns/1ps
module tb_dtree_classifier_mc;
  logic        clk = 0;
  logic        reset;
  logic        in_valid, in_ready, cfg_we, cfg_ready, out_valid, out_ready;
  logic [3:0]  in_channel, out_channel;
  logic [23:0] in_features, cfg_data;
  logic [6:0]  cfg_addr;
  logic [1:0]  out_level;
  logic [2:0]  out_path;

  logic        o_in_valid, o_in_ready, o_cfg_ready, o_out_valid;
  logic [3:0]  o_in_channel, o_out_channel;
  logic [1:0]  o_out_level;
  logic [2:0]  o_out_path;

  int checks = 0;
  int failures = 0;

  typedef struct {int ch; int level; int path; int lat;} exp_t;
  exp_t sb[$];
  logic [23:0] tbl [0:111];

  always #5 clk = ~clk;

  dtree_classifier_mc u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_channel(in_channel), .in_features(in_features), .cfg_we(cfg_we),
    .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
    .out_level(out_level), .out_path(out_path));

  // Twelve channels leave a 4-bit channel id with out-of-range codes.
  dtree_classifier_mc #(.CHANNEL_COUNT(12)) u_oor (
    .clk(clk), .reset(reset), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_channel(o_in_channel), .in_features(24'h0), .cfg_we(1'b0),
    .cfg_ready(o_cfg_ready), .cfg_addr(7'd0), .cfg_data(24'h0),
    .out_valid(o_out_valid), .out_ready(1'b1), .out_channel(o_out_channel),
    .out_level(o_out_level), .out_path(o_out_path));

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk_node(input int flags, input int c0, input int c1,
                                          input int c2, input int bias);
    logic [1:0] f; logic [3:0] a, b, c; logic [9:0] bb;
    f = flags[1:0]; a = c0[3:0]; b = c1[3:0]; c = c2[3:0]; bb = bias[9:0];
    return {f, c, b, a, bb};
  endfunction

  function automatic exp_t model(input int ch, input logic [23:0] xv);
    exp_t e; int node; int depth; int acc; logic [23:0] d; bit dir; bit done;
    logic signed [9:0] sb10; logic signed [3:0] c; logic signed [7:0] xx;
    e.ch = ch; e.path = 0; e.level = 0; node = 0; depth = 0; done = 0;
    while (!done) begin
      d = tbl[ch*7 + node];
      sb10 = d[9:0];
      acc = int'(sb10);
      for (int k = 0; k < 3; k++) begin
        c = d[10 + 4*k +: 4];
        xx = xv[8*k +: 8];
        acc += int'(c) * int'(xx);
      end
      dir = (acc >= 0);
      if (dir) e.path = e.path | (1 << depth);
      if (d[22 + int'(dir)] && depth < 2) begin
        node = 2*node + 1 + int'(dir);
        depth++;
      end else begin
        e.level = depth + 1;
        done = 1;
      end
    end
    e.lat = 5*e.level + 1;
    return e;
  endfunction

  task automatic cfg_write(input int addr, input logic [23:0] data);
    @(negedge clk);
    cfg_we = 1; cfg_addr = addr[6:0]; cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 0;
    if (addr < 112) tbl[addr] = data;
  endtask

  task automatic send(input int ch, input logic [23:0] xv, input bit push);
    @(negedge clk);
    in_valid = 1; in_channel = ch[3:0]; in_features = xv;
    if (push) sb.push_back(model(ch, xv));
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic get_result(input int hold);
    exp_t e; int n;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    out_ready = (hold == 0);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!out_valid && n < 200);
    check_eq("latency", n, e.lat);
    check_eq("out_channel", out_channel, e.ch);
    check_eq("out_level", out_level, e.level);
    check_eq("out_path", out_path, e.path);
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin
        cfg_we = 1; cfg_addr = 7'd14; cfg_data = 24'hFFFFFF;
      end else cfg_we = 0;
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_cfg_ready", cfg_ready, 0);
      check_eq("hold_level", out_level, e.level);
      check_eq("hold_path", out_path, e.path);
      check_eq("hold_channel", out_channel, e.ch);
    end
    cfg_we = 0;
    out_ready = 1;
    @(negedge clk);
    check_eq("post_hs_valid", out_valid, 0);
    check_eq("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int n; bit seen;
    logic [23:0] x1, x3;
    reset = 1; in_valid = 0; in_channel = 0; in_features = 0;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0; out_ready = 1;
    o_in_valid = 0; o_in_channel = 0;
    for (int i = 0; i < 112; i++) tbl[i] = 24'h0;
    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_cfg_ready", cfg_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_channel", out_channel, 0);
    check_eq("rst_out_level", out_level, 0);
    check_eq("rst_out_path", out_path, 0);
    check_eq("rst_oor_out_valid", o_out_valid, 0);
    @(negedge clk); reset = 0;

    for (int i = 0; i < 112; i++) cfg_write(i, 24'h0);

    // single node, acc == 0 goes right
    cfg_write(2*7, mk_node(0, 1, -2, 3, -5));
    x1 = {8'd1, 8'd1, 8'd4};
    send(2, x1, 1); get_result(0);

    // full depth 0 -> 1 -> 4
    cfg_write(3*7 + 0, mk_node(3, 0, 0, 0, -1));
    cfg_write(3*7 + 1, mk_node(3, 0, 0, 0, 5));
    cfg_write(3*7 + 4, mk_node(3, 0, 0, 0, 0));
    x3 = {8'd9, 8'd8, 8'd7};
    send(3, x3, 1); get_result(0);

    // right-only flags with left decision stops at depth 1
    cfg_write(4*7, mk_node(2, 0, 0, 0, -3));
    send(4, x1, 1); get_result(0);

    // extremes and per-channel isolation
    cfg_write(0*7 + 0, mk_node(3, -8, -8, -8, -512));
    cfg_write(0*7 + 1, mk_node(0, 0, 0, 0, 7));
    cfg_write(15*7 + 0, mk_node(0, 0, 0, 0, 100));
    send(0, {3{8'd127}}, 1); get_result(0);
    send(15, {3{8'd127}}, 1); get_result(0);

    // backpressure, write during hold must be dropped
    send(2, x1, 1); get_result(10);
    send(2, x1, 1); get_result(0);

    // out-of-range cfg address is ignored
    cfg_write(120, 24'hABCDEF);
    send(3, x3, 1); get_result(0);

    // spike and table write on the same edge
    cfg_write(6*7, mk_node(0, 1, 1, 1, 0));
    @(negedge clk);
    in_valid = 1; in_channel = 4'd6; in_features = {8'd200, 8'd0, 8'd0};
    cfg_we = 1; cfg_addr = 7'(6*7); cfg_data = mk_node(0, 0, 0, 0, 10);
    tbl[6*7] = cfg_data;
    sb.push_back(model(6, in_features));
    @(posedge clk); #1;
    in_valid = 0; cfg_we = 0;
    get_result(0);

    // random trees on channels 5..9
    for (int i = 5*7; i < 10*7; i++) cfg_write(i, 24'($urandom));
    for (int t = 0; t < 20; t++) begin
      send(5 + int'($urandom_range(0, 4)), 24'($urandom), 1);
      get_result(0);
    end

    // reset mid-MAC discards the spike and keeps the table
    send(3, x3, 0);
    @(negedge clk); @(negedge clk);
    #2 reset = 1;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    @(negedge clk); reset = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check_eq("midrst_no_output", int'(seen), 0);
    send(3, x3, 1); get_result(0);
    send(2, x1, 1); get_result(0);

    // out-of-range channel on the 12-channel instance
    @(negedge clk);
    o_in_valid = 1; o_in_channel = 4'd12;
    @(posedge clk); #1;
    o_in_valid = 0;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!o_out_valid && n < 50);
    check_eq("oor_latency", n, 1);
    check_eq("oor_level", o_out_level, 0);
    check_eq("oor_path", o_out_path, 0);
    check_eq("oor_channel", o_out_channel, 12);
    @(negedge clk);
    check_eq("oor_in_ready", o_in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
